// File: rtl/utmi_rx_controller.sv
// -----------------------------------------------------------------------------
// utmi_rx_controller
//
// Receive-side controller behind an NRZI decoder. It looks for the SYNC
// pattern, assembles data bytes LSB first, removes stuffed bits, and flags
// bit-stuff and byte-alignment errors. SE0 on the line ends the packet.
//
// Parameter
//   SYNC_MIN   minimum run of logical-0 bits before the sync-ending 1 (1..7)
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx_enable  in   controller enable; low returns the FSM to IDLE
//   bit_valid  in   bit_in carries a new sample this cycle
//   bit_in     in   NRZI decoder output, 1 = line transition
//   se0        in   line single-ended zero (end of packet)
//   dec_reset  out  reset pulse to the NRZI decoder delay stage
//   rx_active  out  packet in progress
//   rx_valid   out  one-cycle strobe, rx_data holds a new byte
//   rx_data    out  last assembled byte
//   rx_error   out  one-cycle strobe, stuff or alignment error
// -----------------------------------------------------------------------------
module utmi_rx_controller #(
   parameter int SYNC_MIN = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_enable,
   input  logic       bit_valid,
   input  logic       bit_in,
   input  logic       se0,
   output logic       dec_reset,
   output logic       rx_active,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_ERROR = 2'd2,
      S_EOP   = 2'd3
   } state_t;

   localparam logic [2:0] SYNC_MIN_3 = 3'(SYNC_MIN);

   state_t     r_state;
   state_t     w_next_state;

   logic [2:0] r_sync_cnt, w_sync_cnt;
   logic [2:0] r_ones_cnt, w_ones_cnt;
   logic [2:0] r_bit_cnt,  w_bit_cnt;
   logic [7:0] r_shreg,    w_shreg;
   logic [7:0] r_rx_data,  w_rx_data;
   logic       r_rx_valid, w_rx_valid;
   logic       r_rx_error, w_rx_error;
   logic       r_dec_reset, w_dec_reset;
   logic       r_rx_active, w_rx_active;

   // Logical bit: no line transition means 1.
   logic       w_b;
   logic       w_sync_ok;
   logic       w_stuff;

   assign w_b       = ~bit_in;
   assign w_sync_ok = (r_sync_cnt >= SYNC_MIN_3);
   // Six ones in a row: the next valid bit was inserted by the transmitter.
   assign w_stuff   = (r_ones_cnt == 3'd6);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      if (!rx_enable) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bit_valid && w_b && w_sync_ok)
                  w_next_state = S_DATA;
            end
            S_DATA: begin
               // SE0 takes precedence over any bit sampled in the same cycle.
               if (se0)
                  w_next_state = S_EOP;
               else if (bit_valid && w_stuff && w_b)
                  w_next_state = S_ERROR;
            end
            S_ERROR: begin
               if (se0)
                  w_next_state = S_EOP;
            end
            S_EOP: begin
               if (!se0)
                  w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output / datapath next-value logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_sync_cnt  = r_sync_cnt;
      w_ones_cnt  = r_ones_cnt;
      w_bit_cnt   = r_bit_cnt;
      w_shreg     = r_shreg;
      w_rx_data   = r_rx_data;
      w_rx_valid  = 1'b0;
      w_rx_error  = 1'b0;
      w_dec_reset = 1'b0;

      if (!rx_enable) begin
         w_sync_cnt = 3'd0;
         w_ones_cnt = 3'd0;
         w_bit_cnt  = 3'd0;
         w_shreg    = 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bit_valid) begin
                  if (!w_b) begin
                     if (r_sync_cnt != 3'd7)
                        w_sync_cnt = r_sync_cnt + 3'd1;
                  end else begin
                     // Either sync completed or the run was too short;
                     // both cases start counting afresh.
                     w_sync_cnt = 3'd0;
                     w_ones_cnt = 3'd0;
                     w_bit_cnt  = 3'd0;
                     w_shreg    = 8'h00;
                  end
               end
            end
            S_DATA: begin
               if (se0) begin
                  if (r_bit_cnt != 3'd0)
                     w_rx_error = 1'b1;
               end else if (bit_valid) begin
                  if (w_stuff) begin
                     if (w_b)
                        w_rx_error = 1'b1;
                     else
                        w_ones_cnt = 3'd0;
                  end else begin
                     w_shreg    = {w_b, r_shreg[7:1]};
                     w_bit_cnt  = r_bit_cnt + 3'd1;
                     w_ones_cnt = w_b ? (r_ones_cnt + 3'd1) : 3'd0;
                     if (r_bit_cnt == 3'd7) begin
                        w_rx_data  = {w_b, r_shreg[7:1]};
                        w_rx_valid = 1'b1;
                     end
                  end
               end
            end
            S_ERROR: begin
            end
            S_EOP: begin
               if (!se0) begin
                  w_sync_cnt  = 3'd0;
                  w_ones_cnt  = 3'd0;
                  w_bit_cnt   = 3'd0;
                  w_shreg     = 8'h00;
                  w_dec_reset = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end

      w_rx_active = (w_next_state != S_IDLE);
   end

   // -------------------------------------------------------------------------
   // Datapath and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_cnt  <= 3'd0;
         r_ones_cnt  <= 3'd0;
         r_bit_cnt   <= 3'd0;
         r_shreg     <= 8'h00;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_rx_error  <= 1'b0;
         r_dec_reset <= 1'b1;
         r_rx_active <= 1'b0;
      end else begin
         r_sync_cnt  <= w_sync_cnt;
         r_ones_cnt  <= w_ones_cnt;
         r_bit_cnt   <= w_bit_cnt;
         r_shreg     <= w_shreg;
         r_rx_data   <= w_rx_data;
         r_rx_valid  <= w_rx_valid;
         r_rx_error  <= w_rx_error;
         r_dec_reset <= w_dec_reset;
         r_rx_active <= w_rx_active;
      end
   end

   assign dec_reset = r_dec_reset;
   assign rx_active = r_rx_active;
   assign rx_valid  = r_rx_valid;
   assign rx_data   = r_rx_data;
   assign rx_error  = r_rx_error;

endmodule

// File: tb/tb_utmi_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_utmi_rx_controller
//
// Self-checking bench for utmi_rx_controller. Expected bytes are queued as
// stimulus is driven; a monitor pops and compares them on every rx_valid.
// Each scenario task checks its own control outputs inline.
// -----------------------------------------------------------------------------
module tb_utmi_rx_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_enable;
   logic       bit_valid;
   logic       bit_in;
   logic       se0;
   logic       dec_reset;
   logic       rx_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_error;

   int         checks  = 0;
   int         errors  = 0;
   int         n_valid = 0;
   int         n_err   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   utmi_rx_controller #(.SYNC_MIN(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_enable (rx_enable),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .se0       (se0),
      .dec_reset (dec_reset),
      .rx_active (rx_active),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_error  (rx_error)
   );

   // Scoreboard monitor: sample on the falling edge.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         logic [7:0] exp;
         n_valid++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rx_valid: rx_data=%h, no byte queued", rx_data);
         end else begin
            exp = exp_q.pop_front();
            if (rx_data !== exp) begin
               errors++;
               $display("FAIL rx_data_byte: got %h, expected %h", rx_data, exp);
            end
         end
         checks++;
         if (rx_error !== 1'b0) begin
            errors++;
            $display("FAIL valid_error_overlap: rx_error=%b, expected 0 with rx_valid", rx_error);
         end
      end
      if (rx_error === 1'b1) n_err++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected run to finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit_valid = 1'b0;
      se0       = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = ~b;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic send_sync(input int zeros);
      for (int i = 0; i < zeros; i++) send_bit(1'b0);
      send_bit(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] v);
      exp_q.push_back(v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_eop(input string name);
      se0 = 1'b1;
      tick();
      tick();
      checks++;
      if (rx_active !== 1'b1) begin
         errors++;
         $display("FAIL %s_active_in_eop: got %b, expected 1", name, rx_active);
      end
      se0 = 1'b0;
      tick();
      checks++;
      if (rx_active !== 1'b0) begin
         errors++;
         $display("FAIL %s_active_after_eop: got %b, expected 0", name, rx_active);
      end
      checks++;
      if (dec_reset !== 1'b1) begin
         errors++;
         $display("FAIL %s_dec_reset_pulse: got %b, expected 1", name, dec_reset);
      end
      tick();
      checks++;
      if (dec_reset !== 1'b0) begin
         errors++;
         $display("FAIL %s_dec_reset_end: got %b, expected 0", name, dec_reset);
      end
   endtask

   task automatic check_counts(input string name, input int v0, input int e0,
                               input int dv, input int de);
      idle(2);
      checks++;
      if (n_valid - v0 !== dv) begin
         errors++;
         $display("FAIL %s_valid_count: got %0d, expected %0d", name, n_valid - v0, dv);
      end
      checks++;
      if (n_err - e0 !== de) begin
         errors++;
         $display("FAIL %s_error_count: got %0d, expected %0d", name, n_err - e0, de);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL %s_bytes_missing: got %0d pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_enable = 1'b1; bit_valid = 1'b1; bit_in = 1'b0; se0 = 1'b1;
      tick();
      tick();
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active: got %b, expected 0", rx_active); end
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
      checks++;
      if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error: got %b, expected 0", rx_error); end
      checks++;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, expected 00", rx_data); end
      checks++;
      if (dec_reset !== 1'b1) begin errors++; $display("FAIL reset_dec_reset: got %b, expected 1", dec_reset); end
      reset = 1'b0; bit_valid = 1'b0; se0 = 1'b0;
      tick();
      checks++;
      if (dec_reset !== 1'b0) begin errors++; $display("FAIL reset_release_dec_reset: got %b, expected 0", dec_reset); end
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_release_active: got %b, expected 0", rx_active); end
   endtask

   task automatic test_basic_byte();
      int v0 = n_valid;
      int e0 = n_err;
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL basic_active_before_sync: got %b, expected 0", rx_active); end
      send_bit(1'b1);
      checks++;
      if (rx_active !== 1'b1) begin errors++; $display("FAIL basic_active_after_sync: got %b, expected 1", rx_active); end
      send_byte(8'hA5);
      send_eop("basic");
      check_counts("basic", v0, e0, 1, 0);
      checks++;
      if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_rx_data_hold: got %h, expected a5", rx_data); end
   endtask

   task automatic test_stuff_bit();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(6);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_eop("stuff");
      check_counts("stuff", v0, e0, 1, 0);
      checks++;
      if (rx_data !== 8'hFF) begin errors++; $display("FAIL stuff_rx_data: got %h, expected ff", rx_data); end
   endtask

   task automatic test_stuff_error();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(7);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if (rx_error !== 1'b1) begin errors++; $display("FAIL stufferr_pulse: got %b, expected 1", rx_error); end
      tick();
      checks++;
      if (rx_error !== 1'b0) begin errors++; $display("FAIL stufferr_pulse_width: got %b, expected 0", rx_error); end
      for (int i = 0; i < 9; i++) send_bit(i[0]);
      checks++;
      if (rx_active !== 1'b1) begin errors++; $display("FAIL stufferr_active_in_error: got %b, expected 1", rx_active); end
      send_eop("stufferr");
      check_counts("stufferr", v0, e0, 0, 1);
   endtask

   task automatic test_alignment_error();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(7);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      se0 = 1'b1;
      tick();
      checks++;
      if (rx_error !== 1'b1) begin errors++; $display("FAIL align_pulse: got %b, expected 1", rx_error); end
      tick();
      checks++;
      if (rx_error !== 1'b0) begin errors++; $display("FAIL align_pulse_width: got %b, expected 0", rx_error); end
      checks++;
      if (rx_active !== 1'b1) begin errors++; $display("FAIL align_active_in_eop: got %b, expected 1", rx_active); end
      se0 = 1'b0;
      tick();
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL align_active_release: got %b, expected 0", rx_active); end
      check_counts("align", v0, e0, 0, 1);
   endtask

   task automatic test_short_sync();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(4);
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL shortsync_active: got %b, expected 0", rx_active); end
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL shortsync_active_later: got %b, expected 0", rx_active); end
      check_counts("shortsync", v0, e0, 0, 0);
   endtask

   task automatic test_enable_drop();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(7);
      send_byte(8'h3C);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      rx_enable = 1'b0;
      tick();
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL endrop_active: got %b, expected 0", rx_active); end
      checks++;
      if (rx_data !== 8'h3C) begin errors++; $display("FAIL endrop_rx_data: got %h, expected 3c", rx_data); end
      checks++;
      if ({rx_valid, rx_error, dec_reset} !== 3'b000) begin
         errors++;
         $display("FAIL endrop_strobes: got %b, expected 000", {rx_valid, rx_error, dec_reset});
      end
      rx_enable = 1'b1;
      tick();
      send_sync(6);
      send_byte(8'h5A);
      send_eop("endrop");
      check_counts("endrop", v0, e0, 2, 0);
      checks++;
      if (rx_data !== 8'h5A) begin errors++; $display("FAIL endrop_rx_data_after: got %h, expected 5a", rx_data); end
   endtask

   task automatic test_reset_mid();
      int v0 = n_valid;
      int e0 = n_err;
      send_sync(7);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      reset = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      se0 = 1'b1;
      tick();
      checks++;
      if (rx_active !== 1'b0) begin errors++; $display("FAIL rstmid_active: got %b, expected 0", rx_active); end
      checks++;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h, expected 00", rx_data); end
      checks++;
      if ({rx_valid, rx_error, dec_reset} !== 3'b001) begin
         errors++;
         $display("FAIL rstmid_strobes: got %b, expected 001", {rx_valid, rx_error, dec_reset});
      end
      reset = 1'b0;
      bit_valid = 1'b0;
      se0 = 1'b0;
      tick();
      checks++;
      if (dec_reset !== 1'b0) begin errors++; $display("FAIL rstmid_dec_reset_release: got %b, expected 0", dec_reset); end
      check_counts("rstmid", v0, e0, 0, 0);
   endtask

   task automatic test_back_to_back();
      int v0 = n_valid;
      int e0 = n_err;
      logic [7:0] bytes [2];
      bytes[0] = 8'h00;
      bytes[1] = 8'h81;
      send_sync(6);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(bytes[k]);
         for (int i = 0; i < 8; i++) begin
            send_bit(bytes[k][i]);
            if (i[0]) idle(1);
         end
      end
      send_eop("b2b");
      check_counts("b2b", v0, e0, 2, 0);
      checks++;
      if (rx_data !== 8'h81) begin errors++; $display("FAIL b2b_rx_data: got %h, expected 81", rx_data); end
   endtask

   initial begin
      reset = 1'b1; rx_enable = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; se0 = 1'b0;
      test_reset();
      test_basic_byte();
      test_stuff_bit();
      test_stuff_error();
      test_alignment_error();
      test_short_sync();
      test_enable_drop();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
